// File: rtl/rv32_pkg.sv
// rv32_pkg: types and constants shared by the fetch, decode and immediate-extend stages.
//   XLEN/ILEN    datapath and instruction widths
//   NOP          canonical addi x0,x0,0
//   imm_src_e    immediate-format select driven by decode
//   fetch_entry_t one buffered fetch: {instr, pc}
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [ILEN-1:0] instr_t;

  localparam instr_t NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_entry_t;

  // Sequential next PC; wraps mod 2^32.
  function automatic pc_t pc_plus4(input pc_t p);
    return p + pc_t'(4);
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO used for both the fetched-instruction buffer and
// the in-flight pc tag queue.
//   clk, reset  clock, synchronous active-high reset
//   flush       drop all entries (wins over push/pop)
//   push/wdata  write; ignored when full unless a pop happens in the same cycle
//   pop         read-advance; ignored when empty
//   rdata       head entry (undefined when empty)
//   count/empty occupancy
module ifetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL) || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage. Owns the fetch PC, issues word reads over req/gnt with
// in-order rvalid responses, buffers {instr, pc} and hands them to decode on valid/ready.
// A redirect flushes buffered and in-flight fetches and restarts at redirectPc.
//   clk, reset                       clock, synchronous active-high reset
//   imemReq/imemAddr/imemGnt         request side (address is fetch PC)
//   imemRvalid/imemRdata             response side
//   instrValid/instrReady            decode handshake; instr/pc/pcPlus4 are 0 when empty
//   redirect/redirectPc              taken branch/jump, highest priority
//   instrAddrMisaligned              sticky misaligned-target flag
// Build option: define IFETCH_MISALIGN_CHECK_EN to flag misaligned redirect targets and
// halt fetching until reset; otherwise the port is 0 and redirectPc[1:0] is ignored.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter pc_t RESET_PC   = 32'h0000_0000,
  parameter int  FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrAddrMisaligned
);
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  pc_t           fetch_pc, redir_tgt, tag_pc;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, fifo_count, tag_count;
  logic [CW:0]   used;
  logic          fifo_empty, tag_empty, halt;
  logic          grant, rsp, keep, pop;
  fetch_entry_t  head;

  // Every request holds a buffer slot until its word is consumed, so a response can
  // never find the FIFO full.
  assign used     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imemReq  = !reset && !redirect && !halt && (used < CREDITS);
  assign imemAddr = fetch_pc;
  assign grant    = imemReq && imemGnt;
  // With nothing in flight an rvalid can only be a leftover from before reset.
  assign rsp      = imemRvalid && (outstanding != '0);
  assign keep     = rsp && (discard == '0) && !redirect;
  assign pop      = instrValid && instrReady && !redirect;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({grant, rsp})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: ;
    endcase
  end

  // On redirect everything still in flight afterwards belongs to the old path, which
  // already includes any responses that were being discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= redir_tgt;
        discard  <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc <= pc_plus4(fetch_pc);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Tags of discarded responses were flushed at redirect, so only kept responses pop.
  ifetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_tags (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (grant),
    .wdata (fetch_pc),
    .pop   (rsp && (discard == '0)),
    .rdata (tag_pc),
    .count (tag_count),
    .empty (tag_empty)
  );

  ifetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (keep),
    .wdata ({imemRdata, tag_pc}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign instrValid = !fifo_empty;
  assign instr      = fifo_empty ? '0 : head.instr;
  assign pc         = fifo_empty ? '0 : head.pc;
  assign pcPlus4    = fifo_empty ? '0 : pc_plus4(head.pc);
  assign redir_tgt  = {redirectPc[31:2], 2'b00};

  logic unused_tag;
  assign unused_tag = ^{tag_count, tag_empty};

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned;
  always_ff @(posedge clk) begin
    if (reset)                                       misaligned <= 1'b0;
    else if (redirect && (redirectPc[1:0] != 2'b00)) misaligned <= 1'b1;
  end
  assign halt                = misaligned;
  assign instrAddrMisaligned = misaligned;
`else
  logic unused_lsb;
  assign unused_lsb          = ^redirectPc[1:0];
  assign halt                = 1'b0;
  assign instrAddrMisaligned = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with configurable latency, and a
// queue of expected pcs checked against every instruction decode consumes.
module tb_instr_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset, imemReq, imemGnt, imemRvalid, instrValid, instrReady, redirect;
  logic        instrAddrMisaligned;
  logic [31:0] imemAddr, imemRdata, instr, pc, pcPlus4, redirectPc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .pc(pc), .pcPlus4(pcPlus4),
    .redirect(redirect), .redirectPc(redirectPc),
    .instrAddrMisaligned(instrAddrMisaligned)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] rpc; logic [31:0] first; logic [31:0] second; bit rnd; } vec_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0, cyc = 0, lat = 1, n_grants = 0;
  bit          gnt_rand = 0, force_rv = 0, collide_mode = 0, collide_seen = 0;
  logic        tb_ready = 0, tb_redir = 0, tb_reset = 1;
  logic [31:0] tb_rpc = 0;

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at negedge, observe handshakes just after, then take the edge.
  task automatic cycle();
    bit          rv_mem;
    logic [31:0] e;
    @(negedge clk);
    rv_mem     = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imemGnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    imemRvalid = rv_mem || force_rv;
    imemRdata  = rv_mem ? mkdata(mem_q[0].addr) : 32'hBAD0_BAD0;
    reset      = tb_reset;
    instrReady = tb_ready;
    redirect   = tb_redir;
    redirectPc = tb_rpc;
    if (collide_mode && rv_mem && instrValid) begin
      redirect     = 1'b1;
      instrReady   = 1'b1;
      collide_mode = 0;
      collide_seen = 1;
    end
    #1;
    if (imemReq && imemGnt) begin
      mem_q.push_back('{addr: imemAddr, due: cyc + lat});
      n_grants++;
    end
    if (rv_mem) void'(mem_q.pop_front());
    if (instrValid && instrReady && !redirect && !reset) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_instr: got pc %08h expected none", pc);
      end else begin
        e = exp_q.pop_front();
        chk("pc", pc, e);
        chk("instr", instr, mkdata(e));
        chk("pcPlus4", pcPlus4, e + 32'd4);
      end
    end
    if (redirect) exp_q.delete();
    @(posedge clk);
    if (reset) mem_q.delete();
    cyc++;
    tb_redir = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int b;
    b = budget;
    tb_ready = 1;
    while (exp_q.size() > 0 && b > 0) begin cycle(); b--; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d instrs missing expected 0", name, exp_q.size());
    end
  endtask

  task automatic redir_to(input logic [31:0] t);
    tb_rpc = t; tb_redir = 1; cycle();
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   bound;
    tbl[0] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 1'b0};
    tbl[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1};
    tbl[2] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_0014, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 1'b0};
    tbl[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    imemGnt = 0; imemRvalid = 0; imemRdata = 0; instrReady = 0;
    redirect = 0; redirectPc = 0; reset = 1;

    // Reset state
    tb_reset = 1; cycle(); cycle(); #2;
    chk("rst_imemReq", 32'(imemReq), 32'h0);
    chk("rst_instrValid", 32'(instrValid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pcPlus4", pcPlus4, 32'h0);
    chk("rst_misaligned", 32'(instrAddrMisaligned), 32'h0);
    chk("rst_addr", imemAddr, 32'h0);

    // Streaming from RESET_PC; a stray rvalid with nothing in flight is ignored
    tb_reset = 0; tb_ready = 1; n_grants = 0;
    push_seq(32'h0, 16);
    force_rv = 1; cycle(); force_rv = 0; #2;
    chk("first_grant", n_grants, 1);
    chk("stray_rvalid_ignored", 32'(instrValid), 32'h0);
    drain("stream", 100);

    // Decode stall: credits cap fills at FIFO_DEPTH, then resume without loss
    tb_ready = 0; redir_to(32'h200); push_seq(32'h200, 8);
    n_grants = 0; repeat (8) cycle(); #2;
    chk("stall_grants", n_grants, 2);
    chk("stall_req", 32'(imemReq), 32'h0);
    chk("stall_valid", 32'(instrValid), 32'h1);
    chk("stall_head", pc, 32'h200);
    drain("stall", 100);

    // Redirect with two requests in flight: both responses dropped
    lat = 2; redir_to(32'h300); push_seq(32'h300, 4);
    bound = 0;
    while (mem_q.size() < 2 && bound < 20) begin cycle(); bound++; end
    chk("two_outstanding", mem_q.size(), 2);
    redir_to(32'h100); push_seq(32'h100, 4);
    drain("redir_outstanding", 100);
    lat = 1;

    // Redirect collides with rvalid and a would-be pop
    tb_ready = 0; redir_to(32'h400);
    tb_rpc = 32'h500; collide_mode = 1; bound = 0;
    while (!collide_seen && bound < 30) begin cycle(); bound++; end
    collide_mode = 0;
    chk("collide_seen", 32'(collide_seen), 32'h1);
    push_seq(32'h500, 4);
    drain("collide", 100);

    // Table of redirect targets, including wrap past 0xFFFF_FFFC
    for (int i = 0; i < 5; i++) begin
      gnt_rand = tbl[i].rnd;
      redir_to(tbl[i].rpc);
      exp_q.push_back(tbl[i].first);
      exp_q.push_back(tbl[i].second);
      exp_q.push_back(tbl[i].second + 32'd4);
      exp_q.push_back(tbl[i].second + 32'd8);
      drain("vec", 200);
    end
    gnt_rand = 0;

    // Fetch address wraps after granting 0xFFFF_FFFC
    tb_ready = 0; redir_to(32'hFFFF_FFFC); #2;
    chk("redir_addr", imemAddr, 32'hFFFF_FFFC);
    n_grants = 0; bound = 0;
    while (n_grants < 1 && bound < 20) begin cycle(); bound++; end
    #2;
    chk("wrap_addr", imemAddr, 32'h0000_0000);
    push_seq(32'hFFFF_FFFC, 3);
    drain("wrap", 100);

`ifdef IFETCH_MISALIGN_CHECK_EN
    redir_to(32'h0000_0102);
    n_grants = 0; repeat (6) cycle(); #2;
    chk("misaligned_flag", 32'(instrAddrMisaligned), 32'h1);
    chk("misaligned_grants", n_grants, 0);
    chk("misaligned_req", 32'(imemReq), 32'h0);
`else
    redir_to(32'h0000_0106);
    push_seq(32'h104, 2);
    drain("lsb_ignored", 100); #2;
    chk("misaligned_tied", 32'(instrAddrMisaligned), 32'h0);
`endif

    // Reset mid-stream: counters and buffer cleared, fetch restarts at RESET_PC
    tb_ready = 1; redir_to(32'h600); push_seq(32'h600, 8);
    repeat (4) cycle();
    tb_reset = 1; cycle(); exp_q.delete(); tb_reset = 0; #2;
    chk("midrst_valid", 32'(instrValid), 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_addr", imemAddr, 32'h0);
    chk("midrst_misaligned", 32'(instrAddrMisaligned), 32'h0);
    push_seq(32'h0, 4);
    drain("after_reset", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
